serial_width_adapter: RTL and testbench
=======================================

# serial_width_adapter

Bidirectional width adapter between the 32-bit host serial (TSI) link and a narrow off-chip serial link. Host-to-target words are split into NARROW_W-bit beats, least-significant beat first. Target-to-host beats are reassembled into words. It sits directly downstream and upstream of the simulation serial endpoint: the endpoint's serial_in feeds wide_in_*, and wide_out_* drives the endpoint's serial_out.

## Interface
- WIDE_W, 32, wide word width; equals the endpoint's SERIAL_WIDTH
- NARROW_W, 4, narrow beat width; must divide WIDE_W exactly; elaboration error otherwise
- Derived: BEATS = WIDE_W/NARROW_W; CNT_W = max(1, clog2(BEATS))
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- wide_in_valid  in  1  host word available
- wide_in_ready  out  1  adapter accepts host word
- wide_in_bits  in  WIDE_W  host word
- narrow_out_valid  out  1  beat to target valid
- narrow_out_ready  in  1  target accepts beat
- narrow_out_bits  out  NARROW_W  beat to target
- narrow_in_valid  in  1  beat from target valid
- narrow_in_ready  out  1  adapter accepts beat
- narrow_in_bits  in  NARROW_W  beat from target
- wide_out_valid  out  1  reassembled word valid
- wide_out_ready  in  1  host accepts word
- wide_out_bits  out  WIDE_W  reassembled word

## Operation
- All handshakes are ready/valid. A transfer occurs when valid && ready are both high at a rising clock edge. A valid, once asserted, holds with stable bits until its transfer.
- Serializer, states IDLE/SEND:
  - IDLE: narrow_out_valid=0 and wide_in_ready=1. On a wide transfer, latch the word, set tx_cnt=0, and go to SEND.
  - SEND: narrow_out_valid=1 and narrow_out_bits=word[tx_cnt*NARROW_W +: NARROW_W].
  - Each narrow transfer with tx_cnt<BEATS-1 increments tx_cnt.
  - The transfer at tx_cnt==BEATS-1 returns to IDLE.
  - wide_in_ready = IDLE || (SEND && tx_cnt==BEATS-1 && narrow_out_ready). A simultaneous new word is latched and stays in SEND with tx_cnt=0, with no bubble.
- Deserializer, states FILL/FULL:
  - FILL: narrow_in_ready=1. Each beat is written to buf[rx_cnt*NARROW_W +: NARROW_W] and rx_cnt increments.
  - The beat at rx_cnt==BEATS-1 moves to FULL with rx_cnt=0.
  - FULL: wide_out_valid=1 and wide_out_bits=buf.
  - narrow_in_ready = FILL || wide_out_ready. If a word transfer and a beat arrive in the same cycle, the beat is slot 0 of the next word and the state becomes FILL. With BEATS==1, the state stays FULL.
- The two directions are fully independent, with no shared state.
- BEATS==1: each direction degenerates to a one-entry register slice with the same rules.
- No data is dropped or duplicated under any backpressure pattern.

## Timing
- Reset values:
  - wide_in_ready=0, narrow_in_ready=0, narrow_out_valid=0, wide_out_valid=0.
  - narrow_out_bits and wide_out_bits are 0.
  - Counters are 0. The states are IDLE and FILL.
- Readies are forced to 0 while reset is high. They are 1 in the first cycle after reset deasserts.
- Reset mid-word discards any partial word in either direction with no output.
- Serializer latency: the first beat is valid the cycle after the wide transfer. A word takes BEATS cycles at full narrow_out_ready. Sustained throughput is 1 beat per cycle.
- Deserializer latency: wide_out_valid rises the cycle after the last beat's transfer. Sustained throughput is 1 beat per cycle when wide_out_ready is high.
- Combinational paths: narrow_out_ready -> wide_in_ready, and wide_out_ready -> narrow_in_ready. No other input-to-output combinational paths.
- The endpoint registers its ready and valid signals, so these paths create no loop.

## Structure
- Package serial_width_pkg holds:
  - the BEATS/CNT_W derivation functions;
  - typedefs for the serializer state (IDLE, SEND) and deserializer state (FILL, FULL).
- Sub-module serial_width_deser is instantiated once for the deserializer. The serializer is inline in serial_width_adapter.

## Test plan
All scenarios use WIDE_W=32, NARROW_W=4.
- Send host word 0x12345678 with narrow_out_ready=1 -> beats 8,7,6,5,4,3,2,1 on 8 consecutive cycles starting the cycle after the accept; wide_in_ready is high again in the last-beat cycle.
- Send target beats D,E,A,D,B,E,E,F back-to-back with wide_out_ready=1 -> wide_out_bits=0xFEEBDAED and wide_out_valid for exactly 1 cycle, the cycle after beat F.
- Drive 100 random words each way with random ready/valid toggling (50%) -> scoreboards match in order, with no loss or duplication.
- Hold wide_out_ready=0 after a full word and offer a beat -> narrow_in_ready=0 until wide_out_ready rises. The beat is then accepted in the same cycle as the word transfer and becomes slot 0 of the next word.
- Assert reset after 3 of 8 serializer beats and 5 of 8 deserializer beats -> all valids and readies are 0 during reset. The next word in each direction is clean, with no stale nibbles.
- Configure NARROW_W=32 (BEATS=1) -> both directions pass one word per cycle with 1-cycle latency.

Source files
------------

// File: rtl/serial_width_pkg.sv
// Shared types and width derivations for the serial width adapter.
`timescale 1ns/1ps
package serial_width_pkg;

  // Serializer: IDLE waits for a host word, SEND streams its beats.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // Deserializer: FILL collects beats, FULL presents the reassembled word.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } deser_state_e;

  // Number of narrow beats that make up one wide word.
  function automatic int calc_beats(input int wide_w, input int narrow_w);
    return wide_w / narrow_w;
  endfunction

  // Beat counter width; never narrower than one bit so BEATS==1 still has a counter.
  function automatic int calc_cnt_w(input int beats);
    int w;
    w = $clog2(beats);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_width_deser.sv
// Target-to-host direction: gathers NARROW_W-bit beats (LSB beat first)
// into WIDE_W-bit words and offers them on a ready/valid output.
`timescale 1ns/1ps
module serial_width_deser
  import serial_width_pkg::*;
#(
  parameter int WIDE_W   = 32,
  parameter int NARROW_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                narrow_in_valid,
  output logic                narrow_in_ready,
  input  logic [NARROW_W-1:0] narrow_in_bits,
  output logic                wide_out_valid,
  input  logic                wide_out_ready,
  output logic [WIDE_W-1:0]   wide_out_bits
);

  localparam int BEATS = calc_beats(WIDE_W, NARROW_W);
  localparam int CNT_W = calc_cnt_w(BEATS);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  deser_state_e      state_r, state_nxt_s;
  logic [CNT_W-1:0]  rx_cnt_r, rx_cnt_nxt_s;
  logic [WIDE_W-1:0] buf_r, buf_nxt_s;
  logic              beat_fire_s;
  logic              word_fire_s;

  // Handshake outputs; a draining word frees the slot-0 position in the same cycle.
  always_comb begin
    narrow_in_ready = 1'b0;
    if (reset) begin
      narrow_in_ready = 1'b0;
    end else begin
      narrow_in_ready = (state_r == FILL) || wide_out_ready;
    end
    wide_out_valid = (state_r == FULL);
    wide_out_bits  = buf_r;
    beat_fire_s    = narrow_in_valid && narrow_in_ready;
    word_fire_s    = wide_out_valid && wide_out_ready;
  end

  // Next state, beat counter and buffer contents.
  always_comb begin
    state_nxt_s  = state_r;
    rx_cnt_nxt_s = rx_cnt_r;
    buf_nxt_s    = buf_r;
    case (state_r)
      FILL: begin
        if (beat_fire_s) begin
          buf_nxt_s[int'(rx_cnt_r)*NARROW_W +: NARROW_W] = narrow_in_bits;
          if (rx_cnt_r == CNT_LAST) begin
            state_nxt_s  = FULL;
            rx_cnt_nxt_s = CNT_ZERO;
          end else begin
            rx_cnt_nxt_s = rx_cnt_r + CNT_ONE;
          end
        end else begin
          state_nxt_s = FILL;
        end
      end
      FULL: begin
        if (word_fire_s) begin
          if (beat_fire_s) begin
            // The incoming beat is slot 0 of the following word.
            buf_nxt_s[NARROW_W-1:0] = narrow_in_bits;
            if (BEATS == 1) begin
              state_nxt_s  = FULL;
              rx_cnt_nxt_s = CNT_ZERO;
            end else begin
              state_nxt_s  = FILL;
              rx_cnt_nxt_s = CNT_ONE;
            end
          end else begin
            state_nxt_s  = FILL;
            rx_cnt_nxt_s = CNT_ZERO;
          end
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        state_nxt_s  = FILL;
        rx_cnt_nxt_s = CNT_ZERO;
      end
    endcase
  end

  // State, counter and buffer registers; reset drops any partial word.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= FILL;
      rx_cnt_r <= CNT_ZERO;
      buf_r    <= {WIDE_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      rx_cnt_r <= rx_cnt_nxt_s;
      buf_r    <= buf_nxt_s;
    end
  end

endmodule

// File: rtl/serial_width_adapter.sv
// Bidirectional width adapter between the 32-bit host serial link and a
// narrow off-chip link. Host words leave as LSB-first beats; target beats
// are reassembled into host words. The two directions share no state.
`timescale 1ns/1ps
module serial_width_adapter
  import serial_width_pkg::*;
#(
  parameter int WIDE_W   = 32,
  parameter int NARROW_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wide_in_valid,
  output logic                wide_in_ready,
  input  logic [WIDE_W-1:0]   wide_in_bits,
  output logic                narrow_out_valid,
  input  logic                narrow_out_ready,
  output logic [NARROW_W-1:0] narrow_out_bits,
  input  logic                narrow_in_valid,
  output logic                narrow_in_ready,
  input  logic [NARROW_W-1:0] narrow_in_bits,
  output logic                wide_out_valid,
  input  logic                wide_out_ready,
  output logic [WIDE_W-1:0]   wide_out_bits
);

  if ((NARROW_W < 1) || ((WIDE_W % NARROW_W) != 0)) begin : g_bad_width
    $error("serial_width_adapter: NARROW_W must divide WIDE_W exactly");
  end

  localparam int BEATS = calc_beats(WIDE_W, NARROW_W);
  localparam int CNT_W = calc_cnt_w(BEATS);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  ser_state_e        state_r, state_nxt_s;
  logic [CNT_W-1:0]  tx_cnt_r, tx_cnt_nxt_s;
  logic [WIDE_W-1:0] word_r, word_nxt_s;
  logic [WIDE_W-1:0] shifted_s;
  logic              last_s;
  logic              wide_fire_s;
  logic              narrow_fire_s;

  // Serializer handshake outputs; the last beat's acceptance reopens the host side.
  always_comb begin
    last_s           = (tx_cnt_r == CNT_LAST);
    narrow_out_valid = (state_r == SEND);
    shifted_s        = word_r >> (NARROW_W * int'(tx_cnt_r));
    if (state_r == SEND) begin
      narrow_out_bits = shifted_s[NARROW_W-1:0];
    end else begin
      narrow_out_bits = {NARROW_W{1'b0}};
    end
    if (reset) begin
      wide_in_ready = 1'b0;
    end else begin
      wide_in_ready = (state_r == IDLE) ||
                      ((state_r == SEND) && last_s && narrow_out_ready);
    end
    wide_fire_s   = wide_in_valid && wide_in_ready;
    narrow_fire_s = narrow_out_valid && narrow_out_ready;
  end

  // Serializer next state, beat index and held word.
  always_comb begin
    state_nxt_s  = state_r;
    tx_cnt_nxt_s = tx_cnt_r;
    word_nxt_s   = word_r;
    case (state_r)
      IDLE: begin
        if (wide_fire_s) begin
          state_nxt_s  = SEND;
          tx_cnt_nxt_s = CNT_ZERO;
          word_nxt_s   = wide_in_bits;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (narrow_fire_s) begin
          if (last_s) begin
            tx_cnt_nxt_s = CNT_ZERO;
            if (wide_fire_s) begin
              // Back-to-back word: keep streaming with no idle cycle.
              state_nxt_s = SEND;
              word_nxt_s  = wide_in_bits;
            end else begin
              state_nxt_s = IDLE;
            end
          end else begin
            tx_cnt_nxt_s = tx_cnt_r + CNT_ONE;
          end
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        tx_cnt_nxt_s = CNT_ZERO;
      end
    endcase
  end

  // Serializer registers; reset abandons any word in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= IDLE;
      tx_cnt_r <= CNT_ZERO;
      word_r   <= {WIDE_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      tx_cnt_r <= tx_cnt_nxt_s;
      word_r   <= word_nxt_s;
    end
  end

  serial_width_deser #(
    .WIDE_W   (WIDE_W),
    .NARROW_W (NARROW_W)
  ) u_deser (
    .clock           (clock),
    .reset           (reset),
    .narrow_in_valid (narrow_in_valid),
    .narrow_in_ready (narrow_in_ready),
    .narrow_in_bits  (narrow_in_bits),
    .wide_out_valid  (wide_out_valid),
    .wide_out_ready  (wide_out_ready),
    .wide_out_bits   (wide_out_bits)
  );

endmodule

// File: tb/tb_serial_width_adapter.sv
// Scoreboard bench for serial_width_adapter (32/4 instance plus a 32/32 instance).
`timescale 1ns/1ps
module tb_serial_width_adapter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        wide_in_valid = 1'b0;
  logic        wide_in_ready;
  logic [31:0] wide_in_bits = 32'd0;
  logic        narrow_out_valid;
  logic        narrow_out_ready = 1'b0;
  logic [3:0]  narrow_out_bits;
  logic        narrow_in_valid = 1'b0;
  logic        narrow_in_ready;
  logic [3:0]  narrow_in_bits = 4'd0;
  logic        wide_out_valid;
  logic        wide_out_ready = 1'b0;
  logic [31:0] wide_out_bits;

  logic        b1_wide_in_valid = 1'b0;
  logic        b1_wide_in_ready;
  logic [31:0] b1_wide_in_bits = 32'd0;
  logic        b1_narrow_out_valid;
  logic        b1_narrow_out_ready = 1'b0;
  logic [31:0] b1_narrow_out_bits;
  logic        b1_narrow_in_valid = 1'b0;
  logic        b1_narrow_in_ready;
  logic [31:0] b1_narrow_in_bits = 32'd0;
  logic        b1_wide_out_valid;
  logic        b1_wide_out_ready = 1'b0;
  logic [31:0] b1_wide_out_bits;

  int checks = 0;
  int errors = 0;
  logic [3:0]  exp_beats[$];
  logic [31:0] exp_words[$];
  logic        rand_done;

  always #5 clock = ~clock;

  serial_width_adapter #(.WIDE_W(32), .NARROW_W(4)) u_dut (
    .clock(clock), .reset(reset),
    .wide_in_valid(wide_in_valid), .wide_in_ready(wide_in_ready), .wide_in_bits(wide_in_bits),
    .narrow_out_valid(narrow_out_valid), .narrow_out_ready(narrow_out_ready),
    .narrow_out_bits(narrow_out_bits),
    .narrow_in_valid(narrow_in_valid), .narrow_in_ready(narrow_in_ready),
    .narrow_in_bits(narrow_in_bits),
    .wide_out_valid(wide_out_valid), .wide_out_ready(wide_out_ready), .wide_out_bits(wide_out_bits)
  );

  serial_width_adapter #(.WIDE_W(32), .NARROW_W(32)) u_dut1 (
    .clock(clock), .reset(reset),
    .wide_in_valid(b1_wide_in_valid), .wide_in_ready(b1_wide_in_ready),
    .wide_in_bits(b1_wide_in_bits),
    .narrow_out_valid(b1_narrow_out_valid), .narrow_out_ready(b1_narrow_out_ready),
    .narrow_out_bits(b1_narrow_out_bits),
    .narrow_in_valid(b1_narrow_in_valid), .narrow_in_ready(b1_narrow_in_ready),
    .narrow_in_bits(b1_narrow_in_bits),
    .wide_out_valid(b1_wide_out_valid), .wide_out_ready(b1_wide_out_ready),
    .wide_out_bits(b1_wide_out_bits)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Serializer monitor: every accepted beat must match the head of the queue.
  always @(negedge clock) begin
    if (!reset && narrow_out_valid && narrow_out_ready) begin
      if (exp_beats.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ser_beat: unexpected beat %h at %0t", narrow_out_bits, $time);
      end else begin
        chk("ser_beat", {28'd0, narrow_out_bits}, {28'd0, exp_beats.pop_front()});
      end
    end
  end

  // Deserializer monitor: every accepted word must match the head of the queue.
  always @(negedge clock) begin
    if (!reset && wide_out_valid && wide_out_ready) begin
      if (exp_words.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deser_word: unexpected word %h at %0t", wide_out_bits, $time);
      end else begin
        chk("deser_word", wide_out_bits, exp_words.pop_front());
      end
    end
  end

  task automatic host_send(input logic [31:0] w);
    logic [31:0] t;
    logic acc;
    int n;
    for (int k = 0; k < 8; k++) begin
      t = w >> (4 * k);
      exp_beats.push_back(t[3:0]);
    end
    wide_in_valid = 1'b1;
    wide_in_bits  = w;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clock);
      acc = wide_in_ready;
      tick();
      n++;
    end
    wide_in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL host_send: timeout got no accept expected accept of %h", w);
    end
  endtask

  task automatic target_send_beat(input logic [3:0] b);
    logic acc;
    int n;
    narrow_in_valid = 1'b1;
    narrow_in_bits  = b;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clock);
      acc = narrow_in_ready;
      tick();
      n++;
    end
    narrow_in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL target_send: timeout got no accept expected accept of %h", b);
    end
  endtask

  task automatic target_send_word(input logic [31:0] w, input bit gaps);
    logic [31:0] t;
    exp_words.push_back(w);
    for (int k = 0; k < 8; k++) begin
      t = w >> (4 * k);
      target_send_beat(t[3:0]);
      if (gaps) repeat ($urandom_range(0, 1)) tick();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_beats.size() != 0 || exp_words.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_beats_left", 32'(exp_beats.size()), 32'd0);
    chk("drain_words_left", 32'(exp_words.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] b1_w[4];
    logic [31:0] b1_v[4];
    b1_w = '{32'h11111111, 32'hDEADBEEF, 32'h00000001, 32'h80000000};
    b1_v = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h12345678};

    // Reset state.
    tick(); tick();
    @(negedge clock);
    chk("rst_wide_in_ready", {31'd0, wide_in_ready}, 32'd0);
    chk("rst_narrow_in_ready", {31'd0, narrow_in_ready}, 32'd0);
    chk("rst_narrow_out_valid", {31'd0, narrow_out_valid}, 32'd0);
    chk("rst_wide_out_valid", {31'd0, wide_out_valid}, 32'd0);
    chk("rst_narrow_out_bits", {28'd0, narrow_out_bits}, 32'd0);
    chk("rst_wide_out_bits", wide_out_bits, 32'd0);
    chk("rst_b1_readies", {30'd0, b1_wide_in_ready, b1_narrow_in_ready}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_readies", {30'd0, wide_in_ready, narrow_in_ready}, 32'h3);

    // Host word 0x12345678: beats 8..1 on 8 consecutive cycles.
    tick();
    narrow_out_ready = 1'b1;
    host_send(32'h12345678);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("t1_beat_valid", {31'd0, narrow_out_valid}, 32'd1);
      chk("t1_wide_in_ready", {31'd0, wide_in_ready}, (i == 7) ? 32'd1 : 32'd0);
      tick();
    end
    @(negedge clock);
    chk("t1_idle_after", {31'd0, narrow_out_valid}, 32'd0);

    // Target beats D,E,A,D,B,E,E,F -> 0xFEEBDAED for exactly one cycle.
    tick();
    wide_out_ready = 1'b1;
    target_send_word(32'hFEEBDAED, 1'b0);
    @(negedge clock);
    chk("t2_word_valid", {31'd0, wide_out_valid}, 32'd1);
    tick();
    @(negedge clock);
    chk("t2_word_valid_once", {31'd0, wide_out_valid}, 32'd0);

    // Backpressure on the host side with a waiting beat.
    tick();
    wide_out_ready = 1'b0;
    target_send_word(32'h87654321, 1'b0);
    narrow_in_valid = 1'b1;
    narrow_in_bits  = 4'h9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t4_held_ready", {31'd0, narrow_in_ready}, 32'd0);
      chk("t4_held_valid", {31'd0, wide_out_valid}, 32'd1);
      tick();
    end
    exp_words.push_back(32'h0FEDCBA9);
    wide_out_ready = 1'b1;
    @(negedge clock);
    chk("t4_release_ready", {31'd0, narrow_in_ready}, 32'd1);
    tick();
    narrow_in_valid = 1'b0;
    for (int k = 10; k < 17; k++) target_send_beat(4'(k));
    @(negedge clock);
    chk("t4_second_valid", {31'd0, wide_out_valid}, 32'd1);
    drain();

    // Random traffic both ways with 50% ready toggling.
    rand_done = 1'b0;
    fork
      begin
        fork
          begin
            for (int i = 0; i < 100; i++) begin
              w = $urandom;
              host_send(w);
              repeat ($urandom_range(0, 1)) tick();
            end
          end
          begin
            logic [31:0] tw;
            for (int i = 0; i < 100; i++) begin
              tw = $urandom;
              target_send_word(tw, 1'b1);
            end
          end
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          narrow_out_ready = 1'($urandom_range(0, 1));
          wide_out_ready   = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    narrow_out_ready = 1'b1;
    wide_out_ready   = 1'b1;
    drain();

    // Reset mid-word: 3 of 8 serializer beats, 5 of 8 deserializer beats.
    exp_beats.push_back(4'hE);
    exp_beats.push_back(4'hB);
    exp_beats.push_back(4'hA);
    wide_in_valid   = 1'b1;
    wide_in_bits    = 32'hCAFEBABE;
    narrow_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      narrow_in_bits = 4'(i + 1);
      tick();
      if (i == 0) wide_in_valid = 1'b0;
      if (i == 3) narrow_out_ready = 1'b0;
    end
    narrow_in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("t5_forced_readies", {30'd0, wide_in_ready, narrow_in_ready}, 32'd0);
    tick();
    @(negedge clock);
    chk("t5_rst_all", {28'd0, wide_in_ready, narrow_in_ready, narrow_out_valid, wide_out_valid},
        32'd0);
    chk("t5_rst_nbits", {28'd0, narrow_out_bits}, 32'd0);
    chk("t5_rst_wbits", wide_out_bits, 32'd0);
    tick();
    reset = 1'b0;
    narrow_out_ready = 1'b1;
    @(negedge clock);
    chk("t5_post_rst", {28'd0, wide_in_ready, narrow_in_ready, narrow_out_valid, wide_out_valid},
        32'hC);
    tick();
    fork
      host_send(32'h13579BDF);
      target_send_word(32'h0ECA8642, 1'b0);
    join
    drain();

    // BEATS==1: one word per cycle each way, one cycle of latency.
    b1_narrow_out_ready = 1'b1;
    b1_wide_out_ready   = 1'b1;
    b1_wide_in_valid    = 1'b1;
    b1_narrow_in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b1_wide_in_bits   = b1_w[i];
      b1_narrow_in_bits = b1_v[i];
      @(negedge clock);
      chk("b1_readies", {30'd0, b1_wide_in_ready, b1_narrow_in_ready}, 32'h3);
      if (i > 0) begin
        chk("b1_ser_out", b1_narrow_out_bits, b1_w[i-1]);
        chk("b1_deser_out", b1_wide_out_bits, b1_v[i-1]);
        chk("b1_valids", {30'd0, b1_narrow_out_valid, b1_wide_out_valid}, 32'h3);
      end
      tick();
    end
    b1_wide_in_valid   = 1'b0;
    b1_narrow_in_valid = 1'b0;
    @(negedge clock);
    chk("b1_ser_last", b1_narrow_out_bits, b1_w[3]);
    chk("b1_deser_last", b1_wide_out_bits, b1_v[3]);
    tick();
    @(negedge clock);
    chk("b1_idle", {30'd0, b1_narrow_out_valid, b1_wide_out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
